// File: rtl/perf_counter_pkg.sv
// perf_counter_pkg: register map shared by the multi-section performance counter
package perf_counter_pkg;
    localparam logic [1:0] OFS_TIME_LO = 2'd0;
    localparam logic [1:0] OFS_TIME_HI = 2'd1;
    localparam logic [1:0] OFS_EVENT   = 2'd2;
    localparam logic [1:0] OFS_STATUS  = 2'd3;
    localparam logic [1:0] OFS_STOP    = 2'd0;
    localparam logic [1:0] OFS_GO      = 2'd1;
    localparam int ST_RUN  = 0;
    localparam int ST_TOVF = 1;
    localparam int ST_EOVF = 2;
endpackage

// File: rtl/perf_counter_section.sv
// perf_counter_section: one measurement section (time/event counters, sticky overflows, hi shadow)
module perf_counter_section
    import perf_counter_pkg::*;
#(
    parameter int TIME_WIDTH = 64,
    parameter int EVT_WIDTH  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        go,
    input  logic        stop,
    input  logic        gate,
    input  logic        lo_read,
    output logic [31:0] time_lo,
    output logic [31:0] time_hi,
    output logic [31:0] evt,
    output logic [31:0] status
);
    logic [TIME_WIDTH-1:0]  time_q;
    logic [EVT_WIDTH-1:0]   evt_q;
    logic [TIME_WIDTH-33:0] shadow_q;
    logic                   en_q, tovf_q, eovf_q, time_inc, evt_inc;

    assign time_inc = en_q & gate;
    assign evt_inc  = go & gate;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q     <= 1'b0;
            time_q   <= '0;
            evt_q    <= '0;
            shadow_q <= '0;
            tovf_q   <= 1'b0;
            eovf_q   <= 1'b0;
        end else if (clear) begin
            en_q     <= 1'b0;
            time_q   <= '0;
            evt_q    <= '0;
            shadow_q <= '0;
            tovf_q   <= 1'b0;
            eovf_q   <= 1'b0;
        end else begin
            en_q   <= go | (en_q & ~stop);
            tovf_q <= tovf_q | (time_inc & (&time_q));
            eovf_q <= eovf_q | (evt_inc & (&evt_q));
            if (time_inc)
                time_q <= time_q + TIME_WIDTH'(1);
            if (evt_inc)
                evt_q <= evt_q + EVT_WIDTH'(1);
            // hi half frozen at the lo read so a lo-then-hi pair is coherent
            if (lo_read)
                shadow_q <= time_q[TIME_WIDTH-1:32];
        end
    end

    always_comb begin
        status          = '0;
        status[ST_RUN]  = en_q;
        status[ST_TOVF] = tovf_q;
        status[ST_EOVF] = eovf_q;
    end

    assign time_lo = time_q[31:0];
    assign time_hi = 32'(shadow_q);
    assign evt     = 32'(evt_q);
endmodule

// File: rtl/perf_counter_mc.sv
// perf_counter_mc: multi-section Avalon-MM performance counter with optional global gate
module perf_counter_mc
    import perf_counter_pkg::*;
#(
    parameter int NUM_SECTIONS = 3,
    parameter int TIME_WIDTH   = 64,
    parameter int EVT_WIDTH    = 32,
    parameter int GLOBAL_GATE  = 1,
    localparam int ADDR_WIDTH  = $clog2(NUM_SECTIONS) + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  begintransfer,
    input  logic                  write,
    input  logic                  read,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata
);
    logic                    wr_stb, rd_stb, global_clr, gate, unused_wd;
    logic [ADDR_WIDTH-1:0]   sec;
    logic [1:0]              ofs;
    logic [NUM_SECTIONS-1:0] run;
    logic [31:0]             sec_rd [NUM_SECTIONS];
    logic [31:0]             rd_mux;

    assign wr_stb     = write & begintransfer;
    assign rd_stb     = read & begintransfer & ~wr_stb;
    assign sec        = address >> 2;
    assign ofs        = address[1:0];
    assign global_clr = wr_stb & (sec == '0) & (ofs == OFS_STOP) & writedata[0];
    assign gate       = (GLOBAL_GATE != 0) ? (run[0] | (wr_stb & (sec == '0) & (ofs == OFS_GO))) : 1'b1;
    assign unused_wd  = ^writedata[31:1];

    for (genvar n = 0; n < NUM_SECTIONS; n++) begin : g_sec
        logic        hit;
        logic [31:0] time_lo, time_hi, evt, status;
        assign hit = (sec == ADDR_WIDTH'(n));
        perf_counter_section #(
            .TIME_WIDTH(TIME_WIDTH),
            .EVT_WIDTH (EVT_WIDTH)
        ) u_sec (
            .clk    (clk),
            .reset  (reset),
            .clear  (global_clr),
            .go     (wr_stb & hit & (ofs == OFS_GO)),
            .stop   (wr_stb & hit & (ofs == OFS_STOP)),
            .gate   (gate),
            .lo_read(rd_stb & hit & (ofs == OFS_TIME_LO)),
            .time_lo(time_lo),
            .time_hi(time_hi),
            .evt    (evt),
            .status (status)
        );
        assign run[n]    = status[ST_RUN];
        assign sec_rd[n] = (ofs == OFS_TIME_LO) ? time_lo :
                           (ofs == OFS_TIME_HI) ? time_hi :
                           (ofs == OFS_EVENT)   ? evt : status;
    end

    // sections beyond NUM_SECTIONS fall through to zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_SECTIONS; i++)
            if (sec == ADDR_WIDTH'(i))
                rd_mux = sec_rd[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readdata <= '0;
        else if (rd_stb)
            readdata <= rd_mux;
    end
endmodule

// File: tb/tb_perf_counter_mc.sv
// tb_perf_counter_mc: directed checks of the multi-section performance counter
module tb_perf_counter_mc;
    logic        clk = 1'b0, reset = 1'b1, begintransfer = 1'b0, write = 1'b0, read = 1'b0;
    logic [3:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    perf_counter_mc #(
        .NUM_SECTIONS(3),
        .TIME_WIDTH  (40),
        .EVT_WIDTH   (32),
        .GLOBAL_GATE (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .begintransfer(begintransfer),
        .write        (write),
        .read         (read),
        .writedata    (writedata),
        .readdata     (readdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input int s, input int o, input logic [31:0] d);
        address = 4'(s * 4 + o);
        writedata = d;
        write = 1'b1;
        begintransfer = 1'b1;
        @(negedge clk);
        write = 1'b0;
        begintransfer = 1'b0;
    endtask

    task automatic rd(input int s, input int o, input logic [31:0] exp, input string tag);
        address = 4'(s * 4 + o);
        read = 1'b1;
        begintransfer = 1'b1;
        @(negedge clk);
        read = 1'b0;
        begintransfer = 1'b0;
        chk(tag, readdata, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("reset_readdata", readdata, 32'd0);
        reset = 1'b0;
        rd(0, 3, 32'd0, "reset_status");
        rd(0, 0, 32'd0, "reset_time");
        // GO, 10 idle cycles, STOP: enabled for 11 cycles, one event
        wr(0, 1, 0);
        idle(10);
        wr(0, 0, 0);
        rd(0, 0, 32'd11, "s0_time");
        rd(0, 1, 32'd0, "s0_hi");
        rd(0, 2, 32'd1, "s0_event");
        idle(2);
        chk("readdata_hold", readdata, 32'd1);
        rd(0, 3, 32'd0, "s0_status_stopped");
        // s1 enabled but gated off while s0 is stopped
        wr(1, 1, 0);
        idle(3);
        rd(1, 0, 32'd0, "s1_time_gated");
        rd(1, 2, 32'd0, "s1_event_gated");
        rd(1, 3, 32'd1, "s1_status_run");
        // gate open for the GO cycle plus 4 enabled cycles of s0
        wr(0, 1, 0);
        idle(3);
        wr(0, 0, 0);
        rd(1, 0, 32'd5, "s1_time_window");
        rd(0, 0, 32'd15, "s0_time_total");
        rd(0, 2, 32'd2, "s0_event_total");
        // lo/hi pair across the 2^32 carry
        force dut.g_sec[1].u_sec.time_q = 40'h00_FFFF_FFFF;
        idle(1);
        release dut.g_sec[1].u_sec.time_q;
        rd(1, 0, 32'hFFFF_FFFF, "carry_lo_before");
        wr(0, 1, 0);
        wr(0, 0, 0);
        rd(1, 1, 32'd0, "carry_hi_shadow");
        rd(1, 0, 32'd1, "carry_lo_after");
        rd(1, 1, 32'd1, "carry_hi_after");
        // 40-bit wrap after 3 gated cycles
        force dut.g_sec[1].u_sec.time_q = 40'hFF_FFFF_FFFE;
        idle(1);
        release dut.g_sec[1].u_sec.time_q;
        rd(1, 0, 32'hFFFF_FFFE, "wrap_lo_before");
        rd(1, 1, 32'h0000_00FF, "wrap_hi_before");
        wr(0, 1, 0);
        idle(1);
        wr(0, 0, 0);
        rd(1, 0, 32'd1, "wrap_lo");
        rd(1, 1, 32'd0, "wrap_hi");
        rd(1, 3, 32'd3, "wrap_status");
        rd(1, 2, 32'd0, "wrap_event");
        // global reset while running, with a non-zero shadow latched
        force dut.g_sec[1].u_sec.time_q = 40'hAB_0000_0000;
        idle(1);
        release dut.g_sec[1].u_sec.time_q;
        rd(1, 0, 32'd0, "preset_lo");
        wr(0, 1, 0);
        idle(2);
        wr(0, 0, 1);
        rd(0, 0, 32'd0, "greset_s0_time");
        rd(0, 2, 32'd0, "greset_s0_event");
        rd(0, 3, 32'd0, "greset_s0_status");
        rd(1, 1, 32'd0, "greset_s1_shadow");
        rd(1, 0, 32'd0, "greset_s1_time");
        rd(1, 3, 32'd0, "greset_s1_status");
        // asynchronous reset mid-run
        wr(0, 1, 0);
        idle(4);
        rd(0, 0, 32'd4, "run_before_reset");
        reset = 1'b1;
        #1;
        chk("async_reset_readdata", readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd(0, 3, 32'd0, "post_reset_status");
        rd(0, 0, 32'd0, "post_reset_time");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wr(0, 1, 0);
        idle(3);
        rd(0, 0, 32'd3, "resume_time");
        wr(0, 0, 0);
        rd(0, 0, 32'd5, "s0_time_frozen");
        // unmapped section and ignored offsets
        rd(3, 0, 32'd0, "unmapped_lo");
        rd(3, 3, 32'd0, "unmapped_status");
        wr(3, 1, 0);
        wr(3, 0, 1);
        wr(0, 2, 32'hFFFF_FFFF);
        wr(0, 3, 1);
        rd(0, 0, 32'd5, "ignored_writes_time");
        rd(0, 3, 32'd0, "ignored_writes_status");
        rd(0, 2, 32'd1, "ignored_writes_event");
        // simultaneous write and read: GO applies, readdata holds
        address = 4'd1;
        write = 1'b1;
        read = 1'b1;
        begintransfer = 1'b1;
        @(negedge clk);
        write = 1'b0;
        read = 1'b0;
        begintransfer = 1'b0;
        chk("wr_rd_hold", readdata, 32'd1);
        rd(0, 3, 32'd1, "wr_rd_go_applied");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
